// File: rtl/ahb_mem_slave_ws.sv
// ahb_mem_slave_ws: AHB-Lite SRAM slave with lane-strobed writes, programmable wait states and two-cycle ERROR.
module ahb_mem_slave_ws #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam int XW = ADDR_WIDTH - OW;
  localparam int IW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t state, nxt;
  logic [2:0] cnt, cnt_n;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic pend, a_write;
  logic [IW-1:0] a_idx, rd_idx;
  logic [OW-1:0] a_off;
  logic [2:0] a_size;
  logic [XW-1:0] h_idx;
  logic acc, err, wr_en, rd_en;
  logic [NB-1:0] wstrb;
  logic [DATA_WIDTH-1:0] rd_word;
  logic unused;

  assign unused = HTRANS[0];
  assign h_idx = HADDR[ADDR_WIDTH-1:OW];
  assign acc = HSEL & HREADY & HTRANS[1];
  assign err = (h_idx >= XW'(MEM_DEPTH)) | (HSIZE > 3'(OW)) |
               (|(HADDR[OW-1:0] & ~({OW{1'b1}} << HSIZE)));
  // A pending transfer sitting in IDLE is in its final data-phase cycle.
  assign wr_en = pend & a_write & (state == S_IDLE);
  assign rd_en = (acc & ~err & ~HWRITE & (WAIT_STATES == 0)) |
                 ((state == S_WAIT) & (cnt == 3'd1) & ~a_write);
  assign rd_idx = (state == S_WAIT) ? a_idx : h_idx[IW-1:0];
  assign HREADYOUT = (state == S_IDLE) | (state == S_ERR2);
  assign HRESP = (state == S_ERR1) | (state == S_ERR2);

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign wstrb[i] = (i >= int'(a_off)) && (i < int'(a_off) + (1 << a_size));
  end

  // Forward bytes of a write committing on the same edge into the read word.
  always_comb begin
    rd_word = mem[rd_idx];
    for (int i = 0; i < NB; i++)
      if (wr_en && a_idx == rd_idx && wstrb[i]) rd_word[8*i +: 8] = HWDATA[8*i +: 8];
  end

  always_comb begin
    nxt = state;
    cnt_n = cnt;
    if (state == S_IDLE || state == S_ERR2) begin
      nxt = !acc ? S_IDLE : err ? S_ERR1 : (WAIT_STATES > 0) ? S_WAIT : S_IDLE;
      cnt_n = (acc && !err) ? 3'(WAIT_STATES) : 3'd0;
    end else if (state == S_WAIT) begin
      nxt = (cnt == 3'd1) ? S_IDLE : S_WAIT;
      cnt_n = cnt - 3'd1;
    end else
      nxt = S_ERR2;
  end

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state <= S_IDLE;
      cnt <= '0;
      pend <= 1'b0;
      a_write <= 1'b0;
      a_idx <= '0;
      a_off <= '0;
      a_size <= '0;
      HRDATA <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_n;
      if (HREADY) begin
        pend <= acc & ~err;
        a_write <= HWRITE;
        a_idx <= h_idx[IW-1:0];
        a_off <= HADDR[OW-1:0];
        a_size <= HSIZE;
      end
      if (rd_en) HRDATA <= rd_word;
    end

  always_ff @(posedge HCLK)
    if (wr_en)
      for (int i = 0; i < NB; i++)
        if (wstrb[i]) mem[a_idx][8*i +: 8] <= HWDATA[8*i +: 8];
endmodule
